// File: rtl/conv_tap_feeder.sv
// Operand sequencer for the 3x3 convolution accumulator: 9-entry weight bank, serial pixel
// stream, one tap-ordered product per cycle. Define CONV_TAP_FEEDER_SAT_EN to saturate products.
module conv_tap_feeder #(
    parameter int DW   = 8,
    parameter int TAPS = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] prod,
    output logic          prod_valid,
    output logic          prod_last,
    output logic          busy,
    output logic          kernel_ok
);
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [TW-1:0] tap_r, tap_s;
    logic [DW-1:0] weight_r [TAPS];
    logic [DW-1:0] prod_r;
    logic          prod_valid_r, prod_last_r, kernel_ok_r, active_r;
    logic          xfer_s, last_tap_s;

    // Full-width unsigned product reduced to DW bits (wrap, or clamp in the saturating build).
    function automatic logic [DW-1:0] scale_product(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] full;
        full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`ifdef CONV_TAP_FEEDER_SAT_EN
        if (full[2*DW-1:DW] != {DW{1'b0}}) begin
            return {DW{1'b1}};
        end else begin
            return full[DW-1:0];
        end
`else
        return full[DW-1:0];
`endif
    endfunction

    assign xfer_s     = in_valid && active_r;
    assign last_tap_s = (tap_r == TW'(TAPS - 1));

    // Next-state and tap sequencing; clear overrides everything.
    always_comb begin
        state_s = state_r;
        tap_s   = tap_r;
        if (clear) begin
            state_s = ST_IDLE;
            tap_s   = {TW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_req) begin
                        state_s = ST_LOAD_W;
                    end else if (kernel_ok_r && in_valid) begin
                        state_s = ST_STREAM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD_W: begin
                    if (xfer_s && last_tap_s) begin
                        state_s = ST_STREAM;
                        tap_s   = {TW{1'b0}};
                    end else if (xfer_s) begin
                        tap_s = tap_r + TW'(1);
                    end else begin
                        tap_s = tap_r;
                    end
                end
                ST_STREAM: begin
                    if (xfer_s) begin
                        tap_s = last_tap_s ? {TW{1'b0}} : tap_r + TW'(1);
                    end else begin
                        tap_s = tap_r;
                    end
                    // Reload only at a window boundary; a pixel taken this cycle still completes.
                    if (load_req && (tap_r == {TW{1'b0}})) begin
                        state_s = ST_LOAD_W;
                        tap_s   = {TW{1'b0}};
                    end else begin
                        state_s = ST_STREAM;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    tap_s   = {TW{1'b0}};
                end
            endcase
        end
    end

    // State, tap and the registered ready/busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            tap_r    <= {TW{1'b0}};
            active_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            tap_r    <= tap_s;
            active_r <= (state_s != ST_IDLE);
        end
    end

    // Weight bank writes, product issue and kernel-loaded flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                weight_r[i] <= {DW{1'b0}};
            end
            prod_r       <= {DW{1'b0}};
            prod_valid_r <= 1'b0;
            prod_last_r  <= 1'b0;
            kernel_ok_r  <= 1'b0;
        end else begin
            prod_valid_r <= 1'b0;
            prod_last_r  <= 1'b0;
            if (!clear && xfer_s) begin
                if (state_r == ST_LOAD_W) begin
                    weight_r[tap_r] <= in_data;
                    if (last_tap_s) begin
                        kernel_ok_r <= 1'b1;
                    end
                end else begin
                    prod_r       <= scale_product(in_data, weight_r[tap_r]);
                    prod_valid_r <= 1'b1;
                    prod_last_r  <= last_tap_s;
                end
            end
        end
    end

    assign in_ready   = active_r;
    assign busy       = active_r;
    assign prod       = prod_r;
    assign prod_valid = prod_valid_r;
    assign prod_last  = prod_last_r;
    assign kernel_ok  = kernel_ok_r;
endmodule

// File: tb/tb_conv_tap_feeder.sv
// Directed, scoreboarded bench for conv_tap_feeder; expectations follow CONV_TAP_FEEDER_SAT_EN.
module tb_conv_tap_feeder;
    logic       clk = 1'b0;
    logic       rst_n, load_req, clear, in_valid;
    logic [7:0] in_data;
    logic       in_ready, prod_valid, prod_last, busy, kernel_ok;
    logic [7:0] prod;

    int         total  = 0;
    int         passed = 0;
    logic [8:0] sb_q[$];
    logic [7:0] w_m [9];
    int         tap_m;

    conv_tap_feeder dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .prod(prod), .prod_valid(prod_valid), .prod_last(prod_last),
        .busy(busy), .kernel_ok(kernel_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_prod(input int a, input int b);
        int f;
        f = a * b;
`ifdef CONV_TAP_FEEDER_SAT_EN
        return (f > 255) ? 8'd255 : 8'(f);
`else
        return 8'(f % 256);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic lr, input logic clr, input logic v, input logic [7:0] d);
        load_req = lr; clear = clr; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_px(input logic [7:0] px, input logic lr);
        chk("in_ready_px", in_ready, 1);
        sb_q.push_back({model_prod(px, w_m[tap_m]), (tap_m == 8)});
        tap_m = (tap_m == 8) ? 0 : tap_m + 1;
        drive(lr, 1'b0, 1'b1, px);
    endtask

    task automatic load_w(input logic [7:0] w);
        chk("in_ready_ld", in_ready, 1);
        w_m[tap_m] = w;
        tap_m = (tap_m == 8) ? 0 : tap_m + 1;
        drive(1'b0, 1'b0, 1'b1, w);
    endtask

    // Scoreboard: every issued product must match the oldest expected entry.
    always @(negedge clk) begin
        if (prod_valid) begin
            chk("sb_expected_pending", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                logic [8:0] e;
                e = sb_q.pop_front();
                chk("prod", prod, e[8:1]);
                chk("prod_last", prod_last, e[0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; load_req = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        tap_m = 0;
        for (int i = 0; i < 9; i++) w_m[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_prod", prod, 0);
        chk("rst_prod_valid", prod_valid, 0);
        chk("rst_prod_last", prod_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_kernel_ok", kernel_ok, 0);
        rst_n = 1'b1;

        // IDLE ignores in_valid before any kernel is loaded
        drive(1'b0, 1'b0, 1'b1, 8'd7);
        chk("idle_no_kernel_busy", busy, 0);

        // Load weights 1..9, then stream pixels 1..9 back-to-back
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        chk("load_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            chk("load_kernel_ok_low", kernel_ok, 0);
            load_w(8'(i + 1));
        end
        chk("kernel_ok_set", kernel_ok, 1);
        chk("no_prod_during_load", prod_valid, 0);
        for (int i = 0; i < 9; i++) stream_px(8'(i + 1), 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("gap_prod_valid", prod_valid, 0);

        // in_valid toggling: one product per accepted pixel, taps hold across gaps
        for (int i = 0; i < 9; i++) begin
            stream_px(8'(10 + i), 1'b0);
            chk("toggle_pv_hi", prod_valid, 1);
            drive(1'b0, 1'b0, 1'b0, 8'd0);
            chk("toggle_pv_lo", prod_valid, 0);
        end

        // load_req mid-window (tap 4) is ignored
        for (int i = 0; i < 4; i++) stream_px(8'(i + 1), 1'b0);
        stream_px(8'd5, 1'b1);
        for (int i = 5; i < 9; i++) stream_px(8'(i + 1), 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        // load_req at the window boundary: next nine beats are weights
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        chk("reload_in_ready", in_ready, 1);
        load_w(8'd16);
        for (int i = 1; i < 9; i++) load_w(8'(i + 1));
        chk("reload_no_prod", prod_valid, 0);
        stream_px(8'd20, 1'b0);
        stream_px(8'd200, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        // clear in STREAM, then partial load of 3 weights aborted by clear
        drive(1'b0, 1'b1, 1'b1, 8'd33);
        tap_m = 0;
        chk("clear_busy", busy, 0);
        chk("clear_prod_valid", prod_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        load_w(8'd50);
        load_w(8'd60);
        load_w(8'd70);
        drive(1'b0, 1'b1, 1'b1, 8'd99);
        tap_m = 0;
        chk("clr_ld_busy", busy, 0);
        chk("clr_ld_in_ready", in_ready, 0);
        chk("clr_ld_kernel_ok", kernel_ok, 1);
        chk("clr_ld_prod_valid", prod_valid, 0);

        // in_valid in IDLE with a kernel: enters STREAM without consuming the beat
        drive(1'b0, 1'b0, 1'b1, 8'd5);
        chk("idle_to_stream_pv", prod_valid, 0);
        stream_px(8'd5, 1'b0);
        stream_px(8'd2, 1'b0);
        stream_px(8'd3, 1'b0);
        stream_px(8'd1, 1'b0);
        stream_px(8'd1, 1'b0);

        // Reset at tap 5 with a beat presented: everything returns to reset values
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'd9);
        chk("rst2_prod", prod, 0);
        chk("rst2_prod_valid", prod_valid, 0);
        chk("rst2_prod_last", prod_last, 0);
        chk("rst2_kernel_ok", kernel_ok, 0);
        chk("rst2_in_ready", in_ready, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'd9);
        chk("rst2_idle_busy", busy, 0);
        chk("rst2_idle_in_ready", in_ready, 0);
        chk("rst2_idle_pv", prod_valid, 0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conv_tap_feeder.md
# conv_tap_feeder

Operand sequencer for the 3x3 convolution datapath, placed directly upstream of the 9-tap accumulator. It holds a 9-entry kernel weight bank, accepts a serial pixel stream over a valid/ready handshake, and multiplies each pixel by the weight of its tap position. Products are issued one per cycle, tap-ordered 0..8, with a last-tap marker. The accumulator therefore receives exactly nine products per output element.

## Interface
- DW, 8, pixel/weight/product width
- TAPS, 9, taps per window (kernel size 3x3)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low (sampled on rising clk edge)
- load_req  input  1  single-cycle request to (re)load the kernel weights
- clear  input  1  single-cycle abort; returns to IDLE
- in_valid  input  1  in_data valid
- in_data  input  DW  weight (LOAD_W) or pixel (STREAM)
- in_ready  output  1  block accepts in_data this cycle
- prod  output  DW  pixel x weight result for the current tap
- prod_valid  output  1  prod valid this cycle
- prod_last  output  1  prod is tap 8, the last tap of a window
- busy  output  1  state != IDLE
- kernel_ok  output  1  a complete 9-weight load has finished since reset

## Operation
- Transfer on a cycle with in_valid && in_ready.
- States:
  - IDLE: in_ready=0. load_req -> LOAD_W. If kernel_ok=1, in_valid -> STREAM (the beat is not consumed that cycle).
  - LOAD_W: in_ready=1. Each transfer writes weight[tap]; tap increments. On tap 8: tap->0, kernel_ok<=1, next state STREAM.
  - STREAM: in_ready=1. Each transfer computes in_data*weight[tap]; tap increments and wraps 8->0.
- load_req handling:
  - In STREAM, load_req is honoured only when tap==0 (window boundary); otherwise it is ignored, with no pending flag.
  - When honoured: -> LOAD_W on the next cycle. A transfer in that same cycle still completes as a pixel.
- Product arithmetic: unsigned DW x DW gives a 2*DW-bit full product; prod = low DW bits (mod 2^DW). This is overridden by the Configuration macro.
- clear has priority over load_req and transfers:
  - next state IDLE, tap=0, prod_valid=0 the next cycle.
  - Weights and kernel_ok are retained.
  - A transfer in the clear cycle is discarded.
- Partial weight load aborted by clear: weights 0..k-1 are overwritten; kernel_ok keeps its previous value.
- Reset values: state IDLE; tap 0; prod 0; prod_valid 0; prod_last 0; busy 0; kernel_ok 0; weights all 0; in_ready 0.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N gives prod/prod_valid/prod_last registered at edge N+1.
- Throughput: 1 product per cycle. No output backpressure; the accumulator consumes every valid beat.
- prod_valid is a single-cycle pulse per accepted pixel. Gaps in in_valid produce prod_valid=0 cycles, and tap holds during gaps.
- prod_last=1 only together with prod_valid=1 when tap 8 is issued.
- in_ready is a function of registered state only, with no combinational path from in_valid.
- Weight load of 9 weights takes at least 9 cycles. STREAM begins the cycle after the 9th weight transfer.
- rst_n low mid-window: all state is reset at that edge, and the partial window is lost.

## Configuration
- CONV_TAP_FEEDER_SAT_EN:
  - Defined: if the full product > 2^DW-1, prod = 2^DW-1 (saturate).
  - Undefined: prod = low DW bits (wrap).
- Latency is identical in both builds.

## Test plan
- Reset, then load weights 1..9, then stream pixels 1..9 with in_valid held high -> prod = 1,4,9,16,25,36,49,64,81 on consecutive cycles; prod_last only on 81; kernel_ok=1.
- Weight 16 at tap 0, pixel 20 -> full product 320. Wrap build: prod=64. SAT build: prod=255.
- Stream with in_valid toggling every other cycle -> prod_valid toggles; taps stay in order; prod_last on the 9th accepted pixel.
- load_req at tap 4 mid-window -> ignored, products continue. load_req at tap 0 -> in_ready stays 1 and the next 9 beats load as weights.
- clear during LOAD_W after 3 weights -> IDLE; busy=0; kernel_ok unchanged; next in_valid restarts STREAM at tap 0.
- rst_n low for 1 cycle at tap 5 -> next cycle: all outputs 0, kernel_ok=0, in_valid ignored in IDLE.
